// File: rtl/mod_counter_pkg.sv
// Package: mod_counter_pkg
// Shared types and helpers for the modulo-N up/down counter.
//   cnt_op_e    : the operation the counter performs on a given edge
//   clamp_load(): the largest legal count for a given modulus. Loads above
//                 this value are clamped to it.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_CLR  = 2'd1,
    CNT_LOAD = 2'd2,
    CNT_STEP = 2'd3
  } cnt_op_e;

  // Largest count value in the range 0..modulus-1.
  function automatic int unsigned clamp_load(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Module: mod_counter_prescaler
// Tick generator. It counts enabled cycles 0..PRESCALE-1 and raises tick_o
// during the enabled cycle where the count sits at PRESCALE-1. On that same
// cycle the count returns to 0. A disabled cycle holds the count.
// Ports:
//   clk_i   in  clock, rising edge
//   rst_ni  in  asynchronous reset, active-low
//   clr_i   in  synchronous return of the count to 0 (has priority over en_i)
//   en_i    in  count enable
//   tick_o  out combinational: en_i && count == PRESCALE-1
module mod_counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  // Keep at least one bit so that PRESCALE=1 still elaborates.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick_o = en_i && (pcnt == PMAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      pcnt <= '0;
    else if (clr_i)   pcnt <= '0;
    else if (tick_o)  pcnt <= '0;
    else if (en_i)    pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/mod_counter.sv
// Module: mod_counter
// Parametrised modulo-N up/down counter. It supports enable, direction,
// synchronous clear, parallel load with clamp, and wrap or saturate at the
// boundary. A registered terminal-count pulse marks boundary steps.
// Optional feature: define MOD_COUNTER_PRESCALE_EN to insert a prescaler. The
// counter then steps only once every PRESCALE enabled cycles.
// Ports:
//   clk_i       in  clock, rising edge
//   rst_ni      in  asynchronous reset, active-low
//   clr_i       in  synchronous clear (highest priority)
//   load_i      in  synchronous load of load_val_i (clamped to MODULUS-1)
//   load_val_i  in  load value, WIDTH bits
//   en_i        in  count enable
//   up_i        in  1: count up, 0: count down
//   cnt_o       out registered count, always within 0..MODULUS-1
//   tc_o        out registered pulse, high after each boundary step
//   at_max_o    out combinational, cnt_o == MODULUS-1
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 2**WIDTH,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             at_max_o
);

  // Catch illegal parameter sets at elaboration time.
  if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2**WIDTH || PRESCALE < 1) begin : g_param_err
    $error("mod_counter: illegal parameter combination");
  end

  // The arithmetic uses one extra bit. With MODULUS == 2**WIDTH, the bound
  // and the +1 step then fit without a wrap special case.
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(clamp_load(MODULUS));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_q;
  logic             tc_nxt;
  logic             step;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   ld_ext;
  cnt_op_e          op;

`ifdef MOD_COUNTER_PRESCALE_EN
  // Clear and load both restart the prescale period.
  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i | load_i),
    .en_i   (en_i),
    .tick_o (step)
  );
`else
  assign step = en_i;
`endif

  assign cnt_ext = {1'b0, cnt_q};
  assign ld_ext  = {1'b0, load_val_i};

  always_comb begin
    op = CNT_HOLD;
    if (clr_i)       op = CNT_CLR;
    else if (load_i) op = CNT_LOAD;
    else if (step)   op = CNT_STEP;
  end

  always_comb begin
    cnt_nxt = cnt_q;
    tc_nxt  = 1'b0;
    case (op)
      CNT_CLR:  cnt_nxt = '0;
      CNT_LOAD: cnt_nxt = (ld_ext > MAXV) ? WIDTH'(MAXV) : load_val_i;
      CNT_STEP: begin
        if (up_i) begin
          if (cnt_ext == MAXV) begin
            tc_nxt  = 1'b1;
            cnt_nxt = (SATURATE != 0) ? WIDTH'(MAXV) : '0;
          end else begin
            cnt_nxt = WIDTH'(cnt_ext + 1'b1);
          end
        end else begin
          if (cnt_q == '0) begin
            tc_nxt  = 1'b1;
            cnt_nxt = (SATURATE != 0) ? '0 : WIDTH'(MAXV);
          end else begin
            cnt_nxt = WIDTH'(cnt_ext - 1'b1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      tc_q  <= tc_nxt;
    end
  end

  assign cnt_o    = cnt_q;
  assign tc_o     = tc_q;
  assign at_max_o = (cnt_ext == MAXV);

endmodule

// File: tb/tb_mod_counter.sv
// Directed testbench for mod_counter with WIDTH=3 and MODULUS=6. A wrap
// instance and a saturate instance share the same stimulus. If
// MOD_COUNTER_PRESCALE_EN is defined, the bench runs only the prescaler
// sequence.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, en, up;
  logic [2:0] load_val;
  logic [2:0] w_cnt, s_cnt;
  logic       w_tc, s_tc, w_max, s_max;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .PRESCALE(4)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_i(up), .cnt_o(w_cnt), .tc_o(w_tc), .at_max_o(w_max));

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1), .PRESCALE(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_i(up), .cnt_o(s_cnt), .tc_o(s_tc), .at_max_o(s_max));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 3'd0;
    #12;
    chk("rst_w_cnt", w_cnt, 0);
    chk("rst_w_tc",  w_tc,  0);
    chk("rst_s_cnt", s_cnt, 0);
    chk("rst_w_max", w_max, 0);
    rst_n = 1'b1;

`ifdef MOD_COUNTER_PRESCALE_EN
    begin
      logic [2:0] exp_p [12] = '{3'd0,3'd0,3'd0,3'd1,3'd1,3'd1,3'd1,3'd2,3'd2,3'd2,3'd2,3'd3};
      tick();
      en = 1'b1; up = 1'b1;
      for (int k = 0; k < 12; k++) begin
        tick();
        chk($sformatf("pre_cnt%0d", k), w_cnt, exp_p[k]);
        chk($sformatf("pre_tc%0d", k),  w_tc,  0);
      end
      // Two enabled cycles, then a clear. The next step needs a full period.
      tick(); tick();
      chk("pre_mid_cnt", w_cnt, 3);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("pre_clr_cnt", w_cnt, 0);
      tick(); tick(); tick();
      chk("pre_after_clr3", w_cnt, 0);
      tick();
      chk("pre_after_clr4", w_cnt, 1);
    end
`else
    begin
      logic [2:0] exp_wu [8] = '{3'd1,3'd2,3'd3,3'd4,3'd5,3'd0,3'd1,3'd2};
      logic       exp_wt [8] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
      logic [2:0] exp_su [8] = '{3'd1,3'd2,3'd3,3'd4,3'd5,3'd5,3'd5,3'd5};
      logic       exp_st [8] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
      logic [2:0] exp_wd [3] = '{3'd5,3'd4,3'd3};
      tick();
      en = 1'b1; up = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick();
        chk($sformatf("up_w_cnt%0d", k), w_cnt, exp_wu[k]);
        chk($sformatf("up_w_tc%0d", k),  w_tc,  exp_wt[k]);
        chk($sformatf("up_s_cnt%0d", k), s_cnt, exp_su[k]);
        chk($sformatf("up_s_tc%0d", k),  s_tc,  exp_st[k]);
        chk($sformatf("up_w_max%0d", k), w_max, exp_wu[k] == 3'd5);
      end
      chk("sat_at_max", s_max, 1);

      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_w_cnt", w_cnt, 0);
      chk("clr_s_cnt", s_cnt, 0);
      chk("clr_s_tc",  s_tc,  0);

      up = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("dn_w_cnt%0d", k), w_cnt, exp_wd[k]);
        chk($sformatf("dn_w_tc%0d", k),  w_tc,  k == 0);
        chk($sformatf("dn_s_cnt%0d", k), s_cnt, 0);
        chk($sformatf("dn_s_tc%0d", k),  s_tc,  1);
      end

      // The load value 7 is clamped to 5. Load wins over the enabled step.
      load = 1'b1; load_val = 3'd7; tick();
      chk("ld7_w_cnt", w_cnt, 5);
      chk("ld7_s_cnt", s_cnt, 5);
      chk("ld7_s_tc",  s_tc,  0);

      clr = 1'b1; load_val = 3'd3; tick(); clr = 1'b0;
      chk("clrld_w_cnt", w_cnt, 0);

      load_val = 3'd4; tick(); load = 1'b0;
      chk("ld4_w_cnt", w_cnt, 4);
      tick();
      chk("dn4_w_cnt", w_cnt, 3);
      en = 1'b0; tick();
      chk("hold_w_cnt", w_cnt, 3);
      chk("hold_w_tc",  w_tc,  0);

      // Reset asserted between edges must take effect without an edge.
      en = 1'b1; up = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_w_cnt", w_cnt, 0);
      chk("arst_s_cnt", s_cnt, 0);
      chk("arst_w_tc",  w_tc,  0);
      tick();
      chk("arst_hold_cnt", w_cnt, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_dn", w_cnt, 5);
      chk("post_rst_tc", w_tc,  1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
